// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a baud-timed
// shift FSM. The serial line is always driven from a flop.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 417,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          uart_txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop, bit_end, stop_end;

  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = wr_valid && !full;
  assign bit_end  = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign stop_end = bit_end && (bit_q == 3'(STOP_BITS - 1));
  // A frame can start from IDLE or straight out of the last stop-bit cycle.
  assign pop      = !empty && ((state_q == IDLE) || ((state_q == STOP) && stop_end));

  assign wr_ready   = !full;
  assign busy       = (state_q != IDLE) || !empty;
  assign fifo_count = count_q;
  assign uart_txd   = txd_q;

  // State, timing and FIFO bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  // FIFO storage; contents past the pointers are don't-care so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  // Next FSM state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_q == 3'd7)) state_d = STOP;
      STOP:    if (stop_end) state_d = empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: baud counter, bit index, shifter, line level
  always_comb begin
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        txd_d = 1'b1;
        if (pop) begin
          shift_d = mem_q[rptr_q];
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          txd_d = shift_q[0];
          bit_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            txd_d = 1'b1;
            bit_d = '0;
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        // bit_q counts stop bits here
        if (stop_end) begin
          bit_d = '0;
          if (pop) begin
            shift_d = mem_q[rptr_q];
            txd_d   = 1'b0;
          end else begin
            txd_d = 1'b1;
          end
        end else if (bit_end) begin
          bit_d = bit_q + 3'd1;
        end
      end
      default: ;
    endcase
  end
endmodule
